// File: rtl/alu_operand_collector_if.sv
// Operand stream into the collector and the registered issue/error bundle out of it.
// slave = collector side, master = upstream driver side.
interface alu_operand_collector_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic         ce;
  logic         mode;
  logic [M-1:0] cmd;
  logic [1:0]   inp_valid;
  logic [N-1:0] opa;
  logic [N-1:0] opb;
  logic         cin;

  logic         issue_valid;
  logic         issue_mode;
  logic [M-1:0] issue_cmd;
  logic [N-1:0] issue_opa;
  logic [N-1:0] issue_opb;
  logic         issue_cin;
  logic         err_timeout;
  logic         err_inval;
  logic         err_cmd;
  logic         busy;

  modport slave (
    input  ce, mode, cmd, inp_valid, opa, opb, cin,
    output issue_valid, issue_mode, issue_cmd, issue_opa, issue_opb, issue_cin,
    output err_timeout, err_inval, err_cmd, busy
  );

  modport master (
    output ce, mode, cmd, inp_valid, opa, opb, cin,
    input  issue_valid, issue_mode, issue_cmd, issue_opa, issue_opb, issue_cin,
    input  err_timeout, err_inval, err_cmd, busy
  );
endinterface

// File: rtl/alu_operand_collector.sv
// ALU front end: decodes operand needs per command, gathers split operands within a
// bounded window, and issues one registered operation or a single-cycle error pulse.
module alu_operand_collector #(
  parameter int N       = 8,
  parameter int M       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  alu_operand_collector_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B} state_t;

  // Returns {cmd_ok, need_a, need_b}.
  function automatic logic [2:0] decode(input logic md, input logic [M-1:0] c);
    logic [31:0] ci;
    logic ok, na, nb;
    ci = 32'(c);
    na = 1'b1;
    nb = 1'b1;
    if (md) begin
      ok = (ci <= 32'd10);
      if (ci == 32'd4 || ci == 32'd5) nb = 1'b0;
      if (ci == 32'd6 || ci == 32'd7) na = 1'b0;
    end else begin
      ok = (ci <= 32'd13);
      if (ci == 32'd6 || ci == 32'd8 || ci == 32'd9) nb = 1'b0;
      if (ci == 32'd7 || ci == 32'd10 || ci == 32'd11) na = 1'b0;
    end
    return {ok, na, nb};
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            pend_mode_q, pend_mode_d;
  logic [M-1:0]    pend_cmd_q, pend_cmd_d;
  logic            pend_cin_q, pend_cin_d;
  logic [N-1:0]    pend_op_q, pend_op_d;
  logic            iss_valid_q, iss_valid_d;
  logic            iss_mode_q, iss_mode_d;
  logic [M-1:0]    iss_cmd_q, iss_cmd_d;
  logic [N-1:0]    iss_opa_q, iss_opa_d;
  logic [N-1:0]    iss_opb_q, iss_opb_d;
  logic            iss_cin_q, iss_cin_d;
  logic            err_to_q, err_to_d;
  logic            err_inval_q, err_inval_d;
  logic            err_cmd_q, err_cmd_d;
  logic            cmd_ok, need_a, need_b, covered;

  assign {cmd_ok, need_a, need_b} = decode(bus.mode, bus.cmd);
  assign covered = (!need_a || bus.inp_valid[0]) && (!need_b || bus.inp_valid[1]);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_mode_d = pend_mode_q;
    pend_cmd_d  = pend_cmd_q;
    pend_cin_d  = pend_cin_q;
    pend_op_d   = pend_op_q;
    iss_valid_d = 1'b0;
    iss_mode_d  = iss_mode_q;
    iss_cmd_d   = iss_cmd_q;
    iss_opa_d   = iss_opa_q;
    iss_opb_d   = iss_opb_q;
    iss_cin_d   = iss_cin_q;
    err_to_d    = 1'b0;
    err_inval_d = 1'b0;
    err_cmd_d   = 1'b0;
    if (bus.ce) begin
      case (state_q)
        IDLE: begin
          if (!cmd_ok) begin
            err_cmd_d = 1'b1;
          end else if (bus.inp_valid == 2'b00) begin
            err_inval_d = 1'b1;
          end else if (covered) begin
            iss_valid_d = 1'b1;
            iss_mode_d  = bus.mode;
            iss_cmd_d   = bus.cmd;
            iss_opa_d   = bus.opa;
            iss_opb_d   = bus.opb;
            iss_cin_d   = bus.cin;
          end else if (need_a && need_b) begin
            // Only one of the two operands is here; hold it and wait for the other.
            pend_mode_d = bus.mode;
            pend_cmd_d  = bus.cmd;
            pend_cin_d  = bus.cin;
            cnt_d       = '0;
            if (bus.inp_valid == 2'b01) begin
              pend_op_d = bus.opa;
              state_d   = WAIT_B;
            end else begin
              pend_op_d = bus.opb;
              state_d   = WAIT_A;
            end
          end else begin
            err_inval_d = 1'b1;
          end
        end
        WAIT_A, WAIT_B: begin
          cnt_d = cnt_inc;
          if ((state_q == WAIT_B && bus.inp_valid[1]) ||
              (state_q == WAIT_A && bus.inp_valid[0])) begin
            iss_valid_d = 1'b1;
            iss_mode_d  = pend_mode_q;
            iss_cmd_d   = pend_cmd_q;
            iss_cin_d   = pend_cin_q;
            iss_opa_d   = (state_q == WAIT_B) ? pend_op_q : bus.opa;
            iss_opb_d   = (state_q == WAIT_B) ? bus.opb : pend_op_q;
            state_d     = IDLE;
            cnt_d       = '0;
          end else if (cnt_inc == TO_VAL) begin
            err_to_d = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pend_mode_q <= 1'b0;
      pend_cmd_q  <= '0;
      pend_cin_q  <= 1'b0;
      pend_op_q   <= '0;
      iss_valid_q <= 1'b0;
      iss_mode_q  <= 1'b0;
      iss_cmd_q   <= '0;
      iss_opa_q   <= '0;
      iss_opb_q   <= '0;
      iss_cin_q   <= 1'b0;
      err_to_q    <= 1'b0;
      err_inval_q <= 1'b0;
      err_cmd_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_mode_q <= pend_mode_d;
      pend_cmd_q  <= pend_cmd_d;
      pend_cin_q  <= pend_cin_d;
      pend_op_q   <= pend_op_d;
      iss_valid_q <= iss_valid_d;
      iss_mode_q  <= iss_mode_d;
      iss_cmd_q   <= iss_cmd_d;
      iss_opa_q   <= iss_opa_d;
      iss_opb_q   <= iss_opb_d;
      iss_cin_q   <= iss_cin_d;
      err_to_q    <= err_to_d;
      err_inval_q <= err_inval_d;
      err_cmd_q   <= err_cmd_d;
    end
  end

  assign bus.issue_valid = iss_valid_q;
  assign bus.issue_mode  = iss_mode_q;
  assign bus.issue_cmd   = iss_cmd_q;
  assign bus.issue_opa   = iss_opa_q;
  assign bus.issue_opb   = iss_opb_q;
  assign bus.issue_cin   = iss_cin_q;
  assign bus.err_timeout = err_to_q;
  assign bus.err_inval   = err_inval_q;
  assign bus.err_cmd     = err_cmd_q;
  assign bus.busy        = (state_q == WAIT_A) || (state_q == WAIT_B);

endmodule

// File: tb/tb_alu_operand_collector.sv
// Scoreboard bench for alu_operand_collector: directed stimulus pushes expected events,
// a negedge monitor pops and compares every pulse the collector produces.
module tb_alu_operand_collector;

  localparam logic [3:0] K_ISS = 4'b1000;
  localparam logic [3:0] K_TO  = 4'b0100;
  localparam logic [3:0] K_INV = 4'b0010;
  localparam logic [3:0] K_CMD = 4'b0001;

  typedef struct {
    logic [3:0] kind;
    int         cyc;
    logic       md;
    logic [3:0] c;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  alu_operand_collector_if #(.N(8), .M(4)) bus ();

  alu_operand_collector #(.N(8), .M(4), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse must match the oldest expectation, at the promised edge.
  always @(negedge clk) begin
    logic [3:0] got;
    exp_t e;
    got = {bus.issue_valid, bus.err_timeout, bus.err_inval, bus.err_cmd};
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_event", 32'(cyc), 32'(e.cyc));
    end
    if (got != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_event", 32'(got), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("event_kind", 32'(got), 32'(e.kind));
        chk("event_cycle", 32'(cyc), 32'(e.cyc));
        if (e.kind == K_ISS) begin
          chk("issue_data", {15'd0, bus.issue_mode, bus.issue_cmd, bus.issue_opa, bus.issue_opb},
              {15'd0, e.md, e.c, e.a, e.b});
          chk("issue_cin", 32'(bus.issue_cin), 32'(e.ci));
        end
      end
    end
  end

  task automatic expect_ev(input logic [3:0] k, input logic md, input logic [3:0] c,
                           input logic [7:0] a, input logic [7:0] b, input logic ci);
    exp_t e;
    e.kind = k; e.cyc = cyc + 1; e.md = md; e.c = c; e.a = a; e.b = b; e.ci = ci;
    sb.push_back(e);
  endtask

  // Present one set of inputs for one edge; returns #1 after that edge.
  task automatic step(input logic ce_v, input logic [1:0] v, input logic md, input logic [3:0] c,
                      input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.ce = ce_v; bus.inp_valid = v; bus.mode = md; bus.cmd = c;
    bus.opa = a; bus.opb = b; bus.cin = ci;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(1'b0, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic wait_step();
    step(1'b1, 2'b00, 1'b1, 4'd15, 8'hEE, 8'hEE, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outputs"}, {16'd0, bus.issue_valid, bus.issue_mode, bus.issue_cmd, bus.issue_cin,
         bus.err_timeout, bus.err_inval, bus.err_cmd, bus.busy, 1'b0}, 32'd0);
    chk({tag, "_data"}, {16'd0, bus.issue_opa, bus.issue_opb}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ce = 1'b0; bus.inp_valid = 2'b00; bus.mode = 1'b0; bus.cmd = 4'd0;
    bus.opa = 8'h00; bus.opb = 8'h00; bus.cin = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Full two-operand issue.
    expect_ev(K_ISS, 1'b1, 4'd0, 8'h12, 8'h34, 1'b1);
    step(1'b1, 2'b11, 1'b1, 4'd0, 8'h12, 8'h34, 1'b1);
    chk("full_busy", 32'(bus.busy), 32'd0);
    idle_step();

    // Split A then B at window edge 5; late fields must not overwrite held ones.
    step(1'b1, 2'b01, 1'b1, 4'd0, 8'h05, 8'h99, 1'b0);
    chk("split_busy_e0", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      wait_step();
      chk("split_busy_wait", 32'(bus.busy), 32'd1);
    end
    expect_ev(K_ISS, 1'b1, 4'd0, 8'h05, 8'h07, 1'b0);
    step(1'b1, 2'b11, 1'b0, 4'd3, 8'hFF, 8'h07, 1'b1);
    chk("split_busy_done", 32'(bus.busy), 32'd0);
    idle_step();

    // Timeout in WAIT_A: error after the 16th enabled edge.
    step(1'b1, 2'b10, 1'b0, 4'd12, 8'h00, 8'hAA, 1'b0);
    for (int i = 1; i <= 15; i++) wait_step();
    chk("to_busy_before", 32'(bus.busy), 32'd1);
    expect_ev(K_TO, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    wait_step();
    chk("to_busy_after", 32'(bus.busy), 32'd0);
    chk("to_data_held", {16'd0, bus.issue_opa, bus.issue_opb}, {16'd0, 8'h05, 8'h07});
    idle_step();

    // Same, but A arrives on the 16th edge: issue wins.
    step(1'b1, 2'b10, 1'b0, 4'd12, 8'h00, 8'hAA, 1'b0);
    for (int i = 1; i <= 15; i++) wait_step();
    expect_ev(K_ISS, 1'b0, 4'd12, 8'h55, 8'hAA, 1'b0);
    step(1'b1, 2'b11, 1'b1, 4'd0, 8'h55, 8'h66, 1'b1);
    idle_step();

    // ce low freezes the counter: 3 + 12 enabled waits, B lands on enabled edge 16.
    step(1'b1, 2'b01, 1'b1, 4'd1, 8'h20, 8'h00, 1'b1);
    for (int i = 1; i <= 3; i++) wait_step();
    for (int i = 0; i < 10; i++) step(1'b0, 2'b10, 1'b1, 4'd0, 8'h00, 8'hCC, 1'b0);
    chk("ce_busy_frozen", 32'(bus.busy), 32'd1);
    for (int i = 1; i <= 12; i++) wait_step();
    expect_ev(K_ISS, 1'b1, 4'd1, 8'h20, 8'h30, 1'b1);
    step(1'b1, 2'b10, 1'b1, 4'd0, 8'h00, 8'h30, 1'b0);
    idle_step();

    // Command range and invalid-input decisions.
    expect_ev(K_CMD, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 2'b11, 1'b1, 4'd11, 8'h01, 8'h02, 1'b0);
    chk("errcmd_data_held", {16'd0, bus.issue_opa, bus.issue_opb}, {16'd0, 8'h20, 8'h30});
    expect_ev(K_CMD, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 2'b11, 1'b0, 4'd14, 8'h01, 8'h02, 1'b0);
    expect_ev(K_CMD, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 2'b00, 1'b0, 4'd15, 8'h01, 8'h02, 1'b0);
    expect_ev(K_ISS, 1'b0, 4'd13, 8'h3C, 8'h03, 1'b0);
    step(1'b1, 2'b11, 1'b0, 4'd13, 8'h3C, 8'h03, 1'b0);
    expect_ev(K_INV, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 2'b00, 1'b1, 4'd0, 8'h01, 8'h02, 1'b0);
    expect_ev(K_INV, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 2'b10, 1'b1, 4'd4, 8'h01, 8'h02, 1'b0);
    expect_ev(K_ISS, 1'b1, 4'd4, 8'h09, 8'h77, 1'b1);
    step(1'b1, 2'b01, 1'b1, 4'd4, 8'h09, 8'h77, 1'b1);
    expect_ev(K_ISS, 1'b0, 4'd10, 8'h44, 8'h81, 1'b0);
    step(1'b1, 2'b10, 1'b0, 4'd10, 8'h44, 8'h81, 1'b0);
    chk("bonly_busy", 32'(bus.busy), 32'd0);
    idle_step();

    // Reset on edge 4 of WAIT_A drops the operation silently.
    step(1'b1, 2'b10, 1'b0, 4'd0, 8'h00, 8'h11, 1'b0);
    for (int i = 1; i <= 3; i++) wait_step();
    reset = 1'b1;
    wait_step();
    reset = 1'b0;
    check_all_zero("midwait_reset");
    for (int i = 0; i < 14; i++) begin
      expect_ev(K_INV, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 2'b00, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
    end
    expect_ev(K_ISS, 1'b1, 4'd8, 8'hA5, 8'h5A, 1'b1);
    step(1'b1, 2'b11, 1'b1, 4'd8, 8'hA5, 8'h5A, 1'b1);
    idle_step();
    idle_step();
    idle_step();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_operand_collector.md
Name: alu_operand_collector

Overview:
- Input-side front end of the ALU core. It receives the `inp_valid`/`opa`/`opb`/`cmd`/`mode`/`cin`/`ce` stream produced by the verification driver or an upstream master.
- It decodes which operands each command needs and collects split operands under a 16-cycle window.
- It issues one registered, complete operation to the execution stage, or raises a timeout, invalid-input or invalid-command error.

Parameters:
- `N`, 8, operand width.
- `M`, 4, command width.
- `TIMEOUT`, 16, number of sample edges in which a missing operand is accepted after a partial operand.

Ports:
- `clk` input 1: clock; all logic on posedge.
- `reset` input 1: synchronous, active-high reset.
- `ce` input 1: clock enable; when low the block holds all state.
- `mode` input 1: 1 = arithmetic, 0 = logical.
- `cmd` input M: command code.
- `inp_valid` input 2: bit0 = `opa` valid, bit1 = `opb` valid.
- `opa` input N: operand A.
- `opb` input N: operand B.
- `cin` input 1: carry in.
- `issue_valid` output 1: one-cycle pulse; the operation is complete.
- `issue_mode` output 1: latched mode.
- `issue_cmd` output M: latched cmd.
- `issue_opa` output N: latched operand A.
- `issue_opb` output N: latched operand B.
- `issue_cin` output 1: latched cin.
- `err_timeout` output 1: one-cycle pulse; missing operand never arrived.
- `err_inval` output 1: one-cycle pulse; `inp_valid` = 00 in IDLE.
- `err_cmd` output 1: one-cycle pulse; cmd out of range for the mode.
- `busy` output 1: high while in WAIT_A or WAIT_B.

Behaviour:
- Reset (synchronous): state = IDLE, counter = 0, all outputs 0 including the issue_* data buses.
- Command encoding, arithmetic (`mode` = 1): 0 ADD, 1 SUB, 2 ADD_CIN, 3 SUB_CIN, 4 INC_A, 5 DEC_A, 6 INC_B, 7 DEC_B, 8 CMP, 9 INC_MUL, 10 SHIFT_MUL; codes 11..15 are invalid.
- Command encoding, logical (`mode` = 0): 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B, 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B, 12 ROL_A_B, 13 ROR_A_B; codes 14..15 are invalid.
- Operand requirement:
  - A-only: arith 4, 5; logic 6, 8, 9.
  - B-only: arith 6, 7; logic 7, 10, 11.
  - All other valid codes need both operands.
- All outputs are registered. A decision taken at edge k is visible in the cycle after edge k. `issue_valid`, `err_timeout`, `err_inval` and `err_cmd` are single-cycle pulses. issue_* data holds its value until the next issue.
- `ce` = 0: no sampling, state and counter frozen, all pulses 0, issue data held.
- IDLE with `ce` = 1, evaluated in this priority order:
  1. Invalid cmd → `err_cmd`; stay IDLE; no latch.
  2. `inp_valid` = 00 → `err_inval`; stay IDLE.
  3. `inp_valid` covers the requirement → latch all fields and pulse `issue_valid`. Unneeded operands are latched as presented.
  4. Two-operand cmd with only 01 → latch mode, cmd, cin and opa; go to WAIT_B; counter = 0.
  5. Two-operand cmd with only 10 → latch mode, cmd, cin and opb; go to WAIT_A; counter = 0.
- A single-operand cmd with only the wrong operand valid (for example A-only cmd with 10) is treated as `err_inval`.
- WAIT_x with `ce` = 1:
  - Counter increments per enabled edge.
  - If `inp_valid` has the missing bit: latch only the missing operand, pulse `issue_valid`, go to IDLE. The held operand and the latched cmd/mode/cin are not overwritten, even with 11.
  - Otherwise, on the edge where the counter reaches TIMEOUT: pulse `err_timeout`, go to IDLE, discard the partial operation.
  - Missing operand arriving on the same edge the counter reaches TIMEOUT → issue wins; no error.
- Window: partial sampled at edge 0, acceptance edges 1..TIMEOUT (enabled edges only).
- The `cmd`/`mode` inputs are ignored during WAIT; a new operation starts only from IDLE.
- No operation is accepted on the edge that issues or times out.
- `reset` asserted mid-WAIT: the operation is dropped and no pulse is emitted.

Test Plan:
- mode=1, cmd=0, inp_valid=11, opa=8'h12, opb=8'h34 → next cycle `issue_valid`=1, `issue_opa`=12, `issue_opb`=34, `issue_cmd`=0, `busy`=0.
- mode=1, cmd=0, inp_valid=01, opa=8'h05; then 10 with opb=8'h07 at edge 5 → `busy`=1 for edges 1..5; `issue_valid` after edge 5 with opa=05, opb=07.
- mode=0, cmd=12, inp_valid=10; no A for 16 edges → `err_timeout` single pulse after edge 16, state IDLE, `issue_valid` never asserted. A then supplied at edge 16 in a rerun → `issue_valid`, no error.
- WAIT_B at counter 3, `ce`=0 for 10 cycles, then opb supplied → counter frozen; issue still accepted; no timeout.
- mode=1, cmd=11 → `err_cmd` pulse. mode=0, cmd=14 → `err_cmd`. mode=0, cmd=13 → accepted. `inp_valid`=00 in IDLE → `err_inval`.
- `reset` pulsed at edge 4 of WAIT_A → all outputs 0, state IDLE, no `err_timeout` at edge 16; next 11 operation issues normally.
